// File: rtl/btb_pkg.sv
// btb_pkg: shared types and helpers for the set-associative branch target buffer.
//   - 2-bit saturating direction counter encodings and width
//   - btb_entry_t: the logical view of one way (valid, tag, target, counter)
//   - cnt_next(): saturating counter step
// Tag and target fields are sized to the widest supported address (XLEN_MAX)
// so one typedef serves every XLEN; narrower builds zero-extend into it.
package btb_pkg;

  localparam int CNT_W    = 2;
  localparam int XLEN_MAX = 64;

  typedef enum logic [CNT_W-1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } cnt_e;

  typedef struct packed {
    logic                valid;
    logic [XLEN_MAX-1:0] tag;
    logic [XLEN_MAX-1:0] target;
    cnt_e                counter;
  } btb_entry_t;

  // One step of the 2-bit saturating counter toward the resolved outcome.
  function automatic cnt_e cnt_next(input cnt_e c, input logic taken);
    cnt_e n;
    case (c)
      STRONG_NT: n = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   n = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    n = taken ? STRONG_T : WEAK_NT;
      default:   n = taken ? STRONG_T : WEAK_T;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btb_plru.sv
// btb_plru: tree pseudo-LRU logic for a single set (purely combinational).
// Ports:
//   state_i     - current PLRU bits of the set (WAYS-1 bits; 1 dummy bit when WAYS=1)
//   touch_way_i - way being made most-recently-used
//   victim_o    - way the tree currently points at for replacement
//   state_o     - PLRU bits after touching touch_way_i
// Encoding: a node bit of 0 points the victim search at the lower half,
// 1 at the upper half. Touching a way flips the path away from it.
module btb_plru
  import btb_pkg::*;
#(
  parameter int WAYS = 2,
  localparam int PW = (WAYS > 1) ? WAYS - 1 : 1,
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [PW-1:0] state_i,
  input  logic [WW-1:0] touch_way_i,
  output logic [WW-1:0] victim_o,
  output logic [PW-1:0] state_o
);

  generate
    if (WAYS == 4) begin : g_four
      // Node 0 is the root, node 1 covers ways 0/1, node 2 covers ways 2/3.
      always_comb begin
        victim_o = state_i[0] ? {1'b1, state_i[2]} : {1'b0, state_i[1]};
        state_o    = state_i;
        state_o[0] = ~touch_way_i[1];
        if (touch_way_i[1]) begin
          state_o[2] = ~touch_way_i[0];
        end else begin
          state_o[1] = ~touch_way_i[0];
        end
      end
    end else if (WAYS == 2) begin : g_two
      always_comb begin
        victim_o = state_i;
        state_o  = ~touch_way_i;
      end
    end else begin : g_one
      // Direct-mapped: there is only ever one candidate.
      logic unused_plru;
      assign unused_plru = ^{state_i, touch_way_i};
      always_comb begin
        victim_o = '0;
        state_o  = '0;
      end
    end
  endgenerate

endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with 2-bit direction counters
// and tree-PLRU replacement.
// Ports:
//   clk, rst                 - rising-edge clock, asynchronous active-low reset
//   pc                       - fetch lookup address (combinational lookup)
//   target_pc/valid/predicted_taken - lookup result (0 on miss)
//   update, update_pc, update_target, update_taken - execute-stage training
//   mispredicted             - redirect flag, feeds statistics only
//   invalidate_all           - clear the whole table (wins over update)
//   update_count, mispredict_count - only with BTB_ASSOC_STATS_EN defined
// Optional feature macro: BTB_ASSOC_STATS_EN (saturating 32-bit statistics).
// Index = addr[log2(SETS)+1:2], tag = addr[XLEN-1:log2(SETS)+2].
// Tag and target storage is not reset; the valid bit alone qualifies an entry.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SETS = 16,
  parameter int WAYS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] target_pc,
  output logic            valid,
  output logic            predicted_taken,
  input  logic            update,
  input  logic [XLEN-1:0] update_pc,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_taken,
  input  logic            mispredicted,
  input  logic            invalidate_all
`ifdef BTB_ASSOC_STATS_EN
  ,
  output logic [31:0]     update_count,
  output logic [31:0]     mispredict_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam int PW    = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Table state: valid/counter/PLRU are reset, tag/target are not.
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] valid_d [SETS];
  cnt_e            cnt_q   [SETS][WAYS];
  cnt_e            cnt_d   [SETS][WAYS];
  logic [TAG_W-1:0] tag_q  [SETS][WAYS];
  logic [TAG_W-1:0] tag_d  [SETS][WAYS];
  logic [XLEN-1:0] tgt_q   [SETS][WAYS];
  logic [XLEN-1:0] tgt_d   [SETS][WAYS];
  logic [PW-1:0]   plru_q  [SETS];
  logic [PW-1:0]   plru_d  [SETS];

  // ---------------------------------------------------------------- lookup
  logic [IDX_W-1:0]    lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  btb_entry_t          lk_e [WAYS];
  logic [WAYS-1:0]     lk_hit;
  logic [XLEN_MAX-1:0] hit_tgt_full;
  logic [CNT_W-1:0]    hit_cnt;

  assign lk_idx = pc[IDX_W+1:2];
  assign lk_tag = pc[XLEN-1:IDX_W+2];

  always_comb begin
    lk_hit       = '0;
    hit_tgt_full = '0;
    hit_cnt      = '0;
    for (int w = 0; w < WAYS; w++) begin
      lk_e[w].valid   = valid_q[lk_idx][w];
      lk_e[w].tag     = XLEN_MAX'(tag_q[lk_idx][w]);
      lk_e[w].target  = XLEN_MAX'(tgt_q[lk_idx][w]);
      lk_e[w].counter = cnt_q[lk_idx][w];
      lk_hit[w] = lk_e[w].valid && (lk_e[w].tag == XLEN_MAX'(lk_tag));
      // At most one way can match, so OR-ing the hit ways is a clean mux.
      if (lk_hit[w]) begin
        hit_tgt_full = hit_tgt_full | lk_e[w].target;
        hit_cnt      = hit_cnt | lk_e[w].counter;
      end
    end
  end

  assign valid           = |lk_hit;
  assign predicted_taken = valid & hit_cnt[1];
  assign target_pc       = hit_tgt_full[XLEN-1:0];

  // ---------------------------------------------------------------- update
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic [WAYS-1:0]  up_hit;
  logic [WW-1:0]    hit_way;
  logic [WW-1:0]    inv_way;
  logic             has_inv;
  logic [WW-1:0]    alloc_way;
  logic [WW-1:0]    touch_way;
  logic [WW-1:0]    plru_victim;
  logic [PW-1:0]    plru_new;

  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[XLEN-1:IDX_W+2];

  always_comb begin
    up_hit  = '0;
    hit_way = '0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      up_hit[w] = valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag);
      if (up_hit[w]) begin
        hit_way = WW'(w);
      end
    end
    // Scan downward so the lowest-numbered invalid way is the one kept.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[up_idx][w]) begin
        inv_way = WW'(w);
      end
    end
  end

  assign has_inv   = ~&valid_q[up_idx];
  assign alloc_way = has_inv ? inv_way : plru_victim;
  assign touch_way = (|up_hit) ? hit_way : alloc_way;

  btb_plru #(
    .WAYS (WAYS)
  ) u_plru (
    .state_i     (plru_q[up_idx]),
    .touch_way_i (touch_way),
    .victim_o    (plru_victim),
    .state_o     (plru_new)
  );

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    plru_d  = plru_q;
    if (invalidate_all) begin
      // Flush wins; any simultaneous update is dropped.
      for (int s = 0; s < SETS; s++) begin
        valid_d[s] = '0;
        plru_d[s]  = '0;
      end
    end else if (update) begin
      if (|up_hit) begin
        cnt_d[up_idx][hit_way] = cnt_next(cnt_q[up_idx][hit_way], update_taken);
        if (update_taken) begin
          tgt_d[up_idx][hit_way] = update_target;
        end
        plru_d[up_idx] = plru_new;
      end else if (update_taken) begin
        // Not-taken misses are never allocated.
        valid_d[up_idx][alloc_way] = 1'b1;
        tag_d[up_idx][alloc_way]   = up_tag;
        tgt_d[up_idx][alloc_way]   = update_target;
        cnt_d[up_idx][alloc_way]   = WEAK_T;
        plru_d[up_idx]             = plru_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
        for (int w = 0; w < WAYS; w++) begin
          cnt_q[s][w] <= STRONG_NT;
        end
      end
    end else begin
      valid_q <= valid_d;
      plru_q  <= plru_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

  // ---------------------------------------------------------------- statistics
`ifdef BTB_ASSOC_STATS_EN
  logic [31:0] update_count_q;
  logic [31:0] update_count_d;
  logic [31:0] mispredict_count_q;
  logic [31:0] mispredict_count_d;
  logic        accepted;

  assign accepted = update & ~invalidate_all;

  always_comb begin
    update_count_d     = update_count_q;
    mispredict_count_d = mispredict_count_q;
    if (accepted && (update_count_q != '1)) begin
      update_count_d = update_count_q + 32'd1;
    end
    if (accepted && mispredicted && (mispredict_count_q != '1)) begin
      mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      update_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      update_count_q     <= update_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign update_count     = update_count_q;
  assign mispredict_count = mispredict_count_q;
`else
  logic unused_stats;
  assign unused_stats = mispredicted;
`endif

  // Byte-offset bits and the zero-extended part of the lookup view carry no information.
  logic unused_lookup;
  assign unused_lookup = ^{pc[1:0], update_pc[1:0], hit_tgt_full, hit_cnt[0]};

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (SETS=16, WAYS=2, XLEN=32).
// Addresses 0x100/0x140/0x180/0x300 all map to set 0 with tags 4/5/6/12;
// 0x144 maps to set 1.
module tb_btb_assoc;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [XLEN-1:0] pc = '0;
  logic [XLEN-1:0] target_pc;
  logic            valid;
  logic            predicted_taken;
  logic            update = 1'b0;
  logic [XLEN-1:0] update_pc = '0;
  logic [XLEN-1:0] update_target = '0;
  logic            update_taken = 1'b0;
  logic            mispredicted = 1'b0;
  logic            invalidate_all = 1'b0;
`ifdef BTB_ASSOC_STATS_EN
  logic [31:0]     update_count;
  logic [31:0]     mispredict_count;
`endif

  int errors = 0;
  int checks = 0;
  int exp_upd = 0;
  int exp_mis = 0;

  always #5 clk = ~clk;

  btb_assoc #(
    .XLEN (XLEN),
    .SETS (16),
    .WAYS (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .target_pc       (target_pc),
    .valid           (valid),
    .predicted_taken (predicted_taken),
    .update          (update),
    .update_pc       (update_pc),
    .update_target   (update_target),
    .update_taken    (update_taken),
    .mispredicted    (mispredicted),
    .invalidate_all  (invalidate_all)
`ifdef BTB_ASSOC_STATS_EN
    ,
    .update_count     (update_count),
    .mispredict_count (mispredict_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] a, input logic v,
                        input logic pt, input logic [31:0] t);
    pc = a;
    #1;
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
    chk({tag, ".taken"}, {31'd0, predicted_taken}, {31'd0, pt});
    chk({tag, ".target"}, target_pc, t);
  endtask

  // One update strobe, taking effect at the next rising edge.
  task automatic upd(input logic [31:0] a, input logic [31:0] t, input logic tk,
                     input logic mp);
    update        = 1'b1;
    update_pc     = a;
    update_target = t;
    update_taken  = tk;
    mispredicted  = mp;
    @(posedge clk);
    #1;
    update       = 1'b0;
    mispredicted = 1'b0;
    exp_upd++;
    if (mp) exp_mis++;
  endtask

  initial begin
    // Reset state
    #2;
    lookup("rst", 32'h100, 1'b0, 1'b0, 32'h0);
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    // First allocation: weakly taken
    upd(32'h100, 32'h200, 1'b1, 1'b0);
    lookup("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

    // Counter walk: 2 -> 1 -> 0, then up to 3 and saturate, then back to 2
    upd(32'h100, 32'h0, 1'b0, 1'b1);
    lookup("nt1", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 32'h0, 1'b0, 1'b0);
    lookup("nt2", 32'h100, 1'b1, 1'b0, 32'h200);
    for (int i = 0; i < 4; i++) upd(32'h100, 32'h200, 1'b1, 1'b0);
    lookup("t4", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 32'h0, 1'b0, 1'b1);
    lookup("sat_nt", 32'h100, 1'b1, 1'b1, 32'h200);

    // Taken hit rewrites the target
    upd(32'h100, 32'h208, 1'b1, 1'b1);
    lookup("retarget", 32'h100, 1'b1, 1'b1, 32'h208);

    // Not-taken miss allocates nothing
    upd(32'h144, 32'h444, 1'b0, 1'b0);
    lookup("nt_miss", 32'h144, 1'b0, 1'b0, 32'h0);

    // Replacement in set 0
    upd(32'h140, 32'h340, 1'b1, 1'b0);
    lookup("way1", 32'h140, 1'b1, 1'b1, 32'h340);
    lookup("way0", 32'h100, 1'b1, 1'b1, 32'h208);
    upd(32'h100, 32'h208, 1'b1, 1'b0);
    upd(32'h180, 32'h380, 1'b1, 1'b0);
    lookup("evicted", 32'h140, 1'b0, 1'b0, 32'h0);
    lookup("kept", 32'h100, 1'b1, 1'b1, 32'h208);
    lookup("new", 32'h180, 1'b1, 1'b1, 32'h380);

    // Lookup and update of the same entry in one cycle: no bypass
    update        = 1'b1;
    update_pc     = 32'h144;
    update_target = 32'h444;
    update_taken  = 1'b1;
    lookup("nobypass", 32'h144, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    update = 1'b0;
    exp_upd++;
    lookup("after", 32'h144, 1'b1, 1'b1, 32'h444);

    // Flush together with a taken update: update dropped, nothing counted
    invalidate_all = 1'b1;
    update         = 1'b1;
    update_pc      = 32'h300;
    update_target  = 32'h600;
    update_taken   = 1'b1;
    @(posedge clk);
    #1;
    invalidate_all = 1'b0;
    update         = 1'b0;
    lookup("inv100", 32'h100, 1'b0, 1'b0, 32'h0);
    lookup("inv300", 32'h300, 1'b0, 1'b0, 32'h0);
    lookup("inv144", 32'h144, 1'b0, 1'b0, 32'h0);

    // Re-allocation after flush
    upd(32'h100, 32'h200, 1'b1, 1'b0);
    lookup("realloc", 32'h100, 1'b1, 1'b1, 32'h200);
`ifdef BTB_ASSOC_STATS_EN
    chk("upd_cnt", update_count, exp_upd);
    chk("mis_cnt", mispredict_count, exp_mis);
`endif

    // Asynchronous reset between edges
    #2 rst = 1'b0;
    lookup("async_rst", 32'h100, 1'b0, 1'b0, 32'h0);
`ifdef BTB_ASSOC_STATS_EN
    chk("upd_cnt_rst", update_count, 32'd0);
    chk("mis_cnt_rst", mispredict_count, 32'd0);
`endif
    // An update presented while reset is held is discarded
    update        = 1'b1;
    update_pc     = 32'h100;
    update_target = 32'h200;
    update_taken  = 1'b1;
    @(posedge clk);
    #2;
    update = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    lookup("post_rst", 32'h100, 1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
